// File: rtl/rob_if.sv
// Reorder buffer bus: dispatch, CDB completion and commit.
// The slave side is the ROB; the master side drives it.
interface rob_if #(
  parameter int ROB_DEPTH = 16
) ();
  localparam int IDX_W = $clog2(ROB_DEPTH);

  logic             dispatch_valid;
  logic [6:0]       dispatch_opcode;
  logic [4:0]       dispatch_rd;
  logic             dispatch_ready;
  logic [IDX_W-1:0] dispatch_rob_idx;
  logic             cdb_valid;
  logic [IDX_W-1:0] cdb_rob_idx;
  logic [31:0]      cdb_data;
  logic             rob_valid;
  logic             rob_ready;
  logic [6:0]       commit_opcode;
  logic [4:0]       commit_rd;
  logic [31:0]      commit_data;
  logic             rob_pop;
  logic             flush;
  logic [IDX_W:0]   rob_count;

  modport slave (
    input  dispatch_valid,
    input  dispatch_opcode,
    input  dispatch_rd,
    output dispatch_ready,
    output dispatch_rob_idx,
    input  cdb_valid,
    input  cdb_rob_idx,
    input  cdb_data,
    output rob_valid,
    output rob_ready,
    output commit_opcode,
    output commit_rd,
    output commit_data,
    input  rob_pop,
    input  flush,
    output rob_count
  );

  modport master (
    output dispatch_valid,
    output dispatch_opcode,
    output dispatch_rd,
    input  dispatch_ready,
    input  dispatch_rob_idx,
    output cdb_valid,
    output cdb_rob_idx,
    output cdb_data,
    input  rob_valid,
    input  rob_ready,
    input  commit_opcode,
    input  commit_rd,
    input  commit_data,
    output rob_pop,
    output flush,
    input  rob_count
  );
endinterface

// File: rtl/rob.sv
// Reorder buffer: in-order allocate and commit,
// out-of-order completion via the CDB.
module rob #(
  parameter int ROB_DEPTH = 16
) (
  input logic  clk,
  input logic  rst_n,
  rob_if.slave bus
);
  localparam int IDX_W = $clog2(ROB_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [ROB_DEPTH-1:0] occ_q;
  logic [ROB_DEPTH-1:0] done_q;
  logic [6:0]           op_q   [ROB_DEPTH];
  logic [4:0]           rd_q   [ROB_DEPTH];
  logic [31:0]          data_q [ROB_DEPTH];

  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] tail_idx;
  logic             full;
  logic             do_disp;
  logic             do_cdb;
  logic             do_pop;

  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];
  assign full = (head_idx == tail_idx) &&
                (head_q[IDX_W] != tail_q[IDX_W]);

  // full comes from registers only, so a pop never frees a slot early
  assign do_disp = bus.dispatch_valid && !full && !bus.flush;
  assign do_cdb  = bus.cdb_valid && occ_q[bus.cdb_rob_idx]
                   && !bus.flush;
  assign do_pop  = bus.rob_pop && occ_q[head_idx]
                   && done_q[head_idx] && !bus.flush;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (bus.flush) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (do_disp) tail_d = tail_q + PTR_W'(1);
      if (do_pop)  head_d = head_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= '0;
      done_q <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        op_q[i]   <= '0;
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else if (bus.flush) begin
      occ_q  <= '0;
      done_q <= '0;
    end else begin
      if (do_disp) begin
        occ_q[tail_idx]  <= 1'b1;
        done_q[tail_idx] <= 1'b0;
        op_q[tail_idx]   <= bus.dispatch_opcode;
        rd_q[tail_idx]   <= bus.dispatch_rd;
        data_q[tail_idx] <= '0;
      end
      if (do_cdb) begin
        done_q[bus.cdb_rob_idx] <= 1'b1;
        data_q[bus.cdb_rob_idx] <= bus.cdb_data;
      end
      if (do_pop) begin
        occ_q[head_idx]  <= 1'b0;
        done_q[head_idx] <= 1'b0;
      end
    end
  end

  assign bus.dispatch_ready   = !full;
  assign bus.dispatch_rob_idx = tail_idx;
  assign bus.rob_valid        = occ_q[head_idx];
  assign bus.rob_ready        = occ_q[head_idx] & done_q[head_idx];
  assign bus.commit_opcode    = op_q[head_idx];
  assign bus.commit_rd        = rd_q[head_idx];
  assign bus.commit_data      = data_q[head_idx];
  assign bus.rob_count        = tail_q - head_q;
endmodule

// File: tb/tb_rob.sv
// Scoreboard bench for rob: dispatch pushes expected commits,
// a negedge monitor checks every retiring head.
module tb_rob;
  typedef struct packed {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   tidx;
  exp_t q[$];

  rob_if #(.ROB_DEPTH(16)) bus ();

  rob #(.ROB_DEPTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: inputs are stable at negedge, so a retiring head is visible
  always @(negedge clk) begin
    if (rst_n && !bus.flush && bus.rob_pop &&
        bus.rob_valid && bus.rob_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL commit_unexpected: got %h expected none",
                 bus.commit_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("commit_op", 32'(bus.commit_opcode), 32'(e.op));
        chk("commit_rd", 32'(bus.commit_rd), 32'(e.rd));
        chk("commit_data", bus.commit_data, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(logic [6:0] op, logic [4:0] rd,
                          logic [31:0] data, bit push);
    exp_t e;
    chk("disp_idx", 32'(bus.dispatch_rob_idx), 32'(tidx % 16));
    e.op   = op;
    e.rd   = rd;
    e.data = data;
    if (push) q.push_back(e);
    bus.dispatch_valid  = 1'b1;
    bus.dispatch_opcode = op;
    bus.dispatch_rd     = rd;
    tick();
    bus.dispatch_valid = 1'b0;
    tidx++;
  endtask

  task automatic complete(int idx, logic [31:0] data);
    bus.cdb_valid   = 1'b1;
    bus.cdb_rob_idx = 4'(idx % 16);
    bus.cdb_data    = data;
    tick();
    bus.cdb_valid = 1'b0;
  endtask

  task automatic pop_n(int n);
    bus.rob_pop = 1'b1;
    repeat (n) tick();
    bus.rob_pop = 1'b0;
  endtask

  task automatic chk_reset_outs(string nm);
    chk({nm, "_dready"}, 32'(bus.dispatch_ready), 32'd1);
    chk({nm, "_didx"}, 32'(bus.dispatch_rob_idx), 32'd0);
    chk({nm, "_valid"}, 32'(bus.rob_valid), 32'd0);
    chk({nm, "_ready"}, 32'(bus.rob_ready), 32'd0);
    chk({nm, "_op"}, 32'(bus.commit_opcode), 32'd0);
    chk({nm, "_rd"}, 32'(bus.commit_rd), 32'd0);
    chk({nm, "_data"}, bus.commit_data, 32'd0);
    chk({nm, "_count"}, 32'(bus.rob_count), 32'd0);
  endtask

  initial begin
    int base;
    int n;
    total = 0;
    bad   = 0;
    tidx  = 0;
    rst_n = 1'b0;
    bus.dispatch_valid  = 1'b0;
    bus.dispatch_opcode = '0;
    bus.dispatch_rd     = '0;
    bus.cdb_valid       = 1'b0;
    bus.cdb_rob_idx     = '0;
    bus.cdb_data        = '0;
    bus.rob_pop         = 1'b0;
    bus.flush           = 1'b0;
    #3;
    chk_reset_outs("rst");
    #9 rst_n = 1'b1;
    tick();

    // single instruction, completion one cycle after dispatch
    dispatch(7'h33, 5'd5, 32'hDEADBEEF, 1'b1);
    bus.cdb_valid   = 1'b1;
    bus.cdb_rob_idx = 4'd0;
    bus.cdb_data    = 32'hDEADBEEF;
    chk("single_valid", 32'(bus.rob_valid), 32'd1);
    chk("single_no_bypass", 32'(bus.rob_ready), 32'd0);
    tick();
    bus.cdb_valid = 1'b0;
    chk("single_ready", 32'(bus.rob_ready), 32'd1);
    chk("single_data", bus.commit_data, 32'hDEADBEEF);
    pop_n(1);
    chk("single_count", 32'(bus.rob_count), 32'd0);

    // fill to 16, then dispatch+pop while full
    base = tidx;
    for (int i = 0; i < 16; i++)
      dispatch(7'(8'h10 + i), 5'(i), 32'h1000 + i, 1'b1);
    chk("full_count", 32'(bus.rob_count), 32'd16);
    chk("full_dready", 32'(bus.dispatch_ready), 32'd0);
    for (int i = 0; i < 16; i++)
      complete(base + i, 32'h1000 + i);
    bus.dispatch_valid  = 1'b1;
    bus.dispatch_opcode = 7'h7F;
    bus.dispatch_rd     = 5'd31;
    bus.rob_pop         = 1'b1;
    tick();
    bus.dispatch_valid = 1'b0;
    bus.rob_pop        = 1'b0;
    chk("full_poppush_count", 32'(bus.rob_count), 32'd15);
    chk("full_poppush_dready", 32'(bus.dispatch_ready), 32'd1);
    chk("full_poppush_didx", 32'(bus.dispatch_rob_idx),
        32'(tidx % 16));
    pop_n(15);
    chk("drain_count", 32'(bus.rob_count), 32'd0);

    // 40 entries, completion order 2,0,1,3 within each group
    for (int g = 0; g < 10; g++) begin
      base = tidx;
      for (int j = 0; j < 4; j++) begin
        n = g * 4 + j;
        dispatch(7'(n), 5'(n), 32'hA5000000 + n, 1'b1);
      end
      complete(base + 2, 32'hA5000000 + g * 4 + 2);
      if (g == 0 || g == 7)
        chk("ooo_head_wait", 32'(bus.rob_ready), 32'd0);
      complete(base + 0, 32'hA5000000 + g * 4 + 0);
      complete(base + 1, 32'hA5000000 + g * 4 + 1);
      complete(base + 3, 32'hA5000000 + g * 4 + 3);
      pop_n(4);
    end
    chk("ooo_count", 32'(bus.rob_count), 32'd0);

    // CDB to an empty entry, pop on a not-ready head
    complete(7, 32'h12345678);
    chk("cdb_empty_count", 32'(bus.rob_count), 32'd0);
    chk("cdb_empty_valid", 32'(bus.rob_valid), 32'd0);
    chk("cdb_empty_didx", 32'(bus.dispatch_rob_idx), 32'(tidx % 16));
    base = tidx;
    dispatch(7'h2A, 5'd3, 32'h0BADF00D, 1'b1);
    pop_n(1);
    chk("nr_pop_valid", 32'(bus.rob_valid), 32'd1);
    chk("nr_pop_ready", 32'(bus.rob_ready), 32'd0);
    chk("nr_pop_count", 32'(bus.rob_count), 32'd1);
    complete(base, 32'h0BADF00D);
    pop_n(1);
    chk("nr_pop_drain", 32'(bus.rob_count), 32'd0);

    // flush with 9 entries, 4 completed; same-cycle ops ignored
    base = tidx;
    for (int i = 0; i < 9; i++)
      dispatch(7'(8'h40 + i), 5'(i), 32'h0, 1'b0);
    for (int i = 0; i < 4; i++)
      complete(base + i, 32'hF0 + i);
    chk("pre_flush_count", 32'(bus.rob_count), 32'd9);
    bus.flush          = 1'b1;
    bus.dispatch_valid = 1'b1;
    bus.cdb_valid      = 1'b1;
    bus.rob_pop        = 1'b1;
    tick();
    bus.flush          = 1'b0;
    bus.dispatch_valid = 1'b0;
    bus.cdb_valid      = 1'b0;
    bus.rob_pop        = 1'b0;
    tidx = 0;
    chk("flush_count", 32'(bus.rob_count), 32'd0);
    chk("flush_valid", 32'(bus.rob_valid), 32'd0);
    chk("flush_didx", 32'(bus.dispatch_rob_idx), 32'd0);
    chk("flush_dready", 32'(bus.dispatch_ready), 32'd1);

    // async reset between edges with 6 entries
    for (int i = 0; i < 6; i++)
      dispatch(7'(8'h50 + i), 5'(i + 1), 32'h0, 1'b0);
    complete(0, 32'hCAFE0000);
    complete(1, 32'hCAFE0001);
    chk("pre_rst_count", 32'(bus.rob_count), 32'd6);
    chk("pre_rst_ready", 32'(bus.rob_ready), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    tidx  = 0;
    tick();
    chk("post_rst_count", 32'(bus.rob_count), 32'd0);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
